conv_window_sequencer: RTL and testbench

Frame-level controller that feeds the Laplacian multiplication stage. It accepts a raster-order stream of 4-bit pixels and keeps two rows in line buffers. For every interior pixel it presents the five cross-shaped taps (north, west, centre, east, south) together with the stage enable. It also tracks downstream pipeline latency so a valid flag and centre coordinates line up with the convolution result.

---
 rtl/conv_window_sequencer_pkg.sv | 23 ++
 rtl/conv_window_sequencer_line_buffer.sv | 26 ++
 rtl/conv_window_sequencer.sv | 163 ++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and constants for the Laplacian window sequencer.
package conv_pkg;

   localparam int PIX_W_DEF = 4;
   localparam int IMG_W_DEF = 8;
   localparam int IMG_H_DEF = 8;

   // Positions of the cross-shaped taps inside the packed tap vector
   localparam int NUM_TAPS = 5;
   localparam int TAP_N    = 0;
   localparam int TAP_W    = 1;
   localparam int TAP_C    = 2;
   localparam int TAP_E    = 3;
   localparam int TAP_S    = 4;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/conv_window_sequencer_line_buffer.sv
// Fixed-depth shift buffer; holds one image row of pixels.
module conv_line_buffer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Shift one pixel in per accepted sample; the oldest entry appears on dout
   always_ff @(posedge clk) begin
      if (shift_en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame controller: buffers two rows, issues cross-shaped Laplacian taps for
// every interior pixel and tracks downstream latency for the result flags.
module conv_window_sequencer
   import conv_pkg::*;
#(
   parameter int IMG_W     = IMG_W_DEF,
   parameter int IMG_H     = IMG_H_DEF,
   parameter int PIX_W     = PIX_W_DEF,
   parameter int STAGE_LAT = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [PIX_W-1:0]         pix_in,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic                     win_enable,
   output logic [PIX_W-1:0]         tap_n,
   output logic [PIX_W-1:0]         tap_w,
   output logic [PIX_W-1:0]         tap_c,
   output logic [PIX_W-1:0]         tap_e,
   output logic [PIX_W-1:0]         tap_s,
   output logic                     res_valid,
   output logic [$clog2(IMG_H)-1:0] res_row,
   output logic [$clog2(IMG_W)-1:0] res_col,
   output logic                     busy,
   output logic                     done
);

   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);
   localparam int DRN_W = $clog2(STAGE_LAT + 2);

   state_t                          state, state_nxt;
   logic [ROW_W-1:0]                in_row;
   logic [COL_W-1:0]                in_col;
   logic [DRN_W-1:0]                drain_cnt;
   logic                            accept, last_pix, win_hit;
   logic [PIX_W-1:0]                lb1_out, lb2_out;
   logic [PIX_W-1:0]                cur_d1, mid_d1, mid_d2, top_d1;
   logic [NUM_TAPS-1:0][PIX_W-1:0]  win_taps, taps_p0;
   logic [ROW_W-1:0]                win_row;
   logic [COL_W-1:0]                win_col;
   logic [ROW_W+COL_W:0]            res_dly [STAGE_LAT];

   assign accept   = pix_ready & pix_valid;
   assign last_pix = accept && (in_row == ROW_W'(IMG_H-1)) && (in_col == COL_W'(IMG_W-1));
   // Accepting (r,c) with r>=2, c>=2 completes the window centred at (r-1,c-1)
   assign win_hit  = accept && (in_row >= ROW_W'(2)) && (in_col >= COL_W'(2));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; DRAIN lasts STAGE_LAT+1 cycles so the last result
   // (issued in the first DRAIN cycle) lands before DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = STREAM;
         STREAM:  if (last_pix) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == DRN_W'(STAGE_LAT)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from the state
   always_comb begin
      pix_ready = (state == STREAM);
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   // Raster position of the next pixel and drain-cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         in_row    <= '0;
         in_col    <= '0;
         drain_cnt <= '0;
      end else begin
         if (accept) begin
            if (in_col == COL_W'(IMG_W-1)) begin
               in_col <= '0;
               in_row <= (in_row == ROW_W'(IMG_H-1)) ? '0 : in_row + 1'b1;
            end else begin
               in_col <= in_col + 1'b1;
            end
         end
         drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      end
   end

   conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_prev (
      .clk      (clk),
      .shift_en (accept),
      .din      (pix_in),
      .dout     (lb1_out)
   );

   conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_prev2 (
      .clk      (clk),
      .shift_en (accept),
      .din      (lb1_out),
      .dout     (lb2_out)
   );

   // Short per-row delays giving the column c-1 / c-2 neighbours at accept time
   always_ff @(posedge clk) begin
      if (accept) begin
         cur_d1 <= pix_in;
         mid_d1 <= lb1_out;
         mid_d2 <= mid_d1;
         top_d1 <= lb2_out;
      end
   end

   // Gather the five taps of the window completed by the current accept
   always_comb begin
      win_taps        = '0;
      win_taps[TAP_N] = top_d1;
      win_taps[TAP_W] = mid_d2;
      win_taps[TAP_C] = mid_d1;
      win_taps[TAP_E] = lb1_out;
      win_taps[TAP_S] = cur_d1;
   end

   // ---- stage p0: register issued window, zero taps when nothing is issued
   always_ff @(posedge clk) begin
      if (reset || !win_hit) begin
         win_enable <= 1'b0;
         taps_p0    <= '0;
         win_row    <= '0;
         win_col    <= '0;
      end else begin
         win_enable <= 1'b1;
         taps_p0    <= win_taps;
         win_row    <= in_row - 1'b1;
         win_col    <= in_col - 1'b1;
      end
   end

   assign tap_n = taps_p0[TAP_N];
   assign tap_w = taps_p0[TAP_W];
   assign tap_c = taps_p0[TAP_C];
   assign tap_e = taps_p0[TAP_E];
   assign tap_s = taps_p0[TAP_S];

   // ---- result tracking: free-running delay matching the downstream stages
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGE_LAT; i++) res_dly[i] <= '0;
      end else begin
         res_dly[0] <= {win_enable, win_row, win_col};
         for (int i = 1; i < STAGE_LAT; i++) res_dly[i] <= res_dly[i-1];
      end
   end

   assign {res_valid, res_row, res_col} = res_dly[STAGE_LAT-1];

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer (3x3, 4x4 and 8x8 instances).
module tb_conv_window_sequencer;

   localparam int LAT = 2;

   typedef struct {
      int n;
      int w;
      int c;
      int e;
      int s;
   } taps_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       st3 = 1'b0, st4 = 1'b0, st8 = 1'b0;
   logic [3:0] pix_in = '0;
   logic       pix_valid = 1'b0;

   logic       rdy3, win3, rv3, busy3, done3;
   logic [3:0] n3, w3, c3, e3, s3;
   logic [1:0] row3, col3;
   logic       rdy4, win4, rv4, busy4, done4;
   logic [3:0] n4, w4, c4, e4, s4;
   logic [1:0] row4, col4;
   logic       rdy8, win8, rv8, busy8, done8;
   logic [3:0] n8, w8, c8, e8, s8;
   logic [2:0] row8, col8;

   conv_window_sequencer #(.IMG_W(3), .IMG_H(3), .PIX_W(4), .STAGE_LAT(LAT)) u3 (
      .clk(clk), .reset(reset), .start(st3), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(rdy3), .win_enable(win3), .tap_n(n3), .tap_w(w3), .tap_c(c3),
      .tap_e(e3), .tap_s(s3), .res_valid(rv3), .res_row(row3), .res_col(col3),
      .busy(busy3), .done(done3));

   conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .PIX_W(4), .STAGE_LAT(LAT)) u4 (
      .clk(clk), .reset(reset), .start(st4), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(rdy4), .win_enable(win4), .tap_n(n4), .tap_w(w4), .tap_c(c4),
      .tap_e(e4), .tap_s(s4), .res_valid(rv4), .res_row(row4), .res_col(col4),
      .busy(busy4), .done(done4));

   conv_window_sequencer #(.IMG_W(8), .IMG_H(8), .PIX_W(4), .STAGE_LAT(LAT)) u8 (
      .clk(clk), .reset(reset), .start(st8), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(rdy8), .win_enable(win8), .tap_n(n8), .tap_w(w8), .tap_c(c8),
      .tap_e(e8), .tap_s(s8), .res_valid(rv8), .res_row(row8), .res_col(col8),
      .busy(busy8), .done(done8));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Selected instance outputs
   int         sel = 4;
   logic       m_rdy, m_win, m_rv, m_busy, m_done;
   logic [3:0] m_n, m_w, m_c, m_e, m_s;
   int         m_row, m_col;

   always_comb begin
      m_rdy = rdy4; m_win = win4; m_rv = rv4; m_busy = busy4; m_done = done4;
      m_n = n4; m_w = w4; m_c = c4; m_e = e4; m_s = s4;
      m_row = int'(row4); m_col = int'(col4);
      if (sel == 3) begin
         m_rdy = rdy3; m_win = win3; m_rv = rv3; m_busy = busy3; m_done = done3;
         m_n = n3; m_w = w3; m_c = c3; m_e = e3; m_s = s3;
         m_row = int'(row3); m_col = int'(col3);
      end else if (sel == 8) begin
         m_rdy = rdy8; m_win = win8; m_rv = rv8; m_busy = busy8; m_done = done8;
         m_n = n8; m_w = w8; m_c = c8; m_e = e8; m_s = s8;
         m_row = int'(row8); m_col = int'(col8);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model state
   int    img [8][8];
   taps_t q_taps [$];
   int    q_pos [$];
   int    q_wcyc [$];
   int    fw = 4, fh = 4, exp_nwin = 0;
   bit    lin_img = 1'b0;
   bit    mon_en = 1'b0;
   int    win_seen = 0, res_seen = 0, done_seen = 0, last_res_cyc = 0;
   int    exp_win_next = 0, acc_cnt = 0;

   // Cycle monitor: window issue timing, taps, result ordering and latency
   always @(negedge clk) begin
      taps_t t;
      int    p, wc, r, c;
      if (mon_en) begin
         check("win_enable", int'(m_win), exp_win_next);
         if (m_win) begin
            win_seen++;
            if (q_taps.size() == 0) begin
               check("extra_window", 1, 0);
            end else begin
               t = q_taps.pop_front();
               check("tap_n", int'(m_n), t.n);
               check("tap_w", int'(m_w), t.w);
               check("tap_c", int'(m_c), t.c);
               check("tap_e", int'(m_e), t.e);
               check("tap_s", int'(m_s), t.s);
               if (lin_img)
                  check("laplacian", 4*int'(m_c) - int'(m_n) - int'(m_w) - int'(m_e) - int'(m_s), 0);
            end
            q_wcyc.push_back(cyc);
         end else begin
            check("taps_zero", int'({m_n, m_w, m_c, m_e, m_s}), 0);
         end
         if (m_rv) begin
            res_seen++;
            last_res_cyc = cyc;
            if (q_pos.size() == 0 || q_wcyc.size() == 0) begin
               check("extra_result", 1, 0);
            end else begin
               p  = q_pos.pop_front();
               wc = q_wcyc.pop_front();
               check("res_row", m_row, p / 16);
               check("res_col", m_col, p % 16);
               check("res_latency", cyc - wc, LAT);
            end
         end
         if (m_done) begin
            done_seen++;
            check("done_after_res", (res_seen == exp_nwin && cyc > last_res_cyc) ? 1 : 0, 1);
         end
         if (reset) begin
            exp_win_next = 0;
            acc_cnt      = 0;
         end else if (pix_valid && m_rdy) begin
            r = acc_cnt / fw;
            c = acc_cnt % fw;
            exp_win_next = (r >= 2 && c >= 2) ? 1 : 0;
            acc_cnt = (acc_cnt + 1) % (fw * fh);
         end else begin
            exp_win_next = 0;
         end
      end
   end

   task automatic set_start(input logic b);
      st3 = (sel == 3) ? b : 1'b0;
      st4 = (sel == 4) ? b : 1'b0;
      st8 = (sel == 8) ? b : 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, int'(m_rdy), 0);
      check({tag, "_win"}, int'(m_win), 0);
      check({tag, "_taps"}, int'({m_n, m_w, m_c, m_e, m_s}), 0);
      check({tag, "_res_valid"}, int'(m_rv), 0);
      check({tag, "_res_row"}, m_row, 0);
      check({tag, "_res_col"}, m_col, 0);
      check({tag, "_busy"}, int'(m_busy), 0);
      check({tag, "_done"}, int'(m_done), 0);
   endtask

   // mode: 0 = valid always, 1 = valid every other cycle, 2 = random valid
   task automatic run_frame(input int s, input int w, input int h, input int mode,
                            input bit dbl_start, input int abort_after);
      int  idx, guard, g;
      bit  v;
      // All instances idle here; build expected windows from the image
      sel = s; fw = w; fh = h;
      q_taps.delete(); q_pos.delete(); q_wcyc.delete();
      for (int r = 1; r <= h - 2; r++) begin
         for (int c = 1; c <= w - 2; c++) begin
            q_taps.push_back('{img[r-1][c], img[r][c-1], img[r][c], img[r][c+1], img[r+1][c]});
            q_pos.push_back(r * 16 + c);
         end
      end
      exp_nwin = (w - 2) * (h - 2);
      win_seen = 0; res_seen = 0; done_seen = 0;
      @(posedge clk); #1;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      check("busy_stream", int'(m_busy), 1);
      idx = 0; guard = 0;
      while (idx < w * h && guard < 4000) begin
         if (abort_after >= 0 && idx == abort_after) begin
            reset = 1'b1; pix_valid = 1'b0;
            @(posedge clk); #1;
            check_zero("abort");
            reset = 1'b0;
            q_taps.delete(); q_pos.delete(); q_wcyc.delete();
            return;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         pix_valid = v;
         pix_in    = 4'(img[idx / w][idx % w]);
         if (dbl_start) set_start(idx == 5);
         if (v && m_rdy) idx++;
         @(posedge clk); #1;
         guard++;
      end
      pix_valid = 1'b0;
      set_start(1'b0);
      check("stream_complete", (idx == w * h) ? 1 : 0, 1);
      check("ready_drain", int'(m_rdy), 0);
      g = 0;
      while (done_seen == 0 && g < 30) begin
         @(posedge clk); #1;
         g++;
      end
      check("done_seen", (done_seen > 0) ? 1 : 0, 1);
      repeat (6) @(posedge clk);
      #1;
      check("windows", win_seen, exp_nwin);
      check("results", res_seen, exp_nwin);
      check("done_pulses", done_seen, 1);
      check("busy_after", int'(m_busy), 0);
      check("model_left", q_taps.size() + q_pos.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b0;
      mon_en = 1'b1;

      // 4x4 linear ramp: all Laplacians are zero
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = (r < 4 && c < 4) ? 4 * r + c : 0;
      lin_img = 1'b1;
      run_frame(4, 4, 4, 0, 1'b0, -1);
      run_frame(4, 4, 4, 1, 1'b0, -1);
      run_frame(4, 4, 4, 0, 1'b1, -1);
      run_frame(4, 4, 4, 0, 1'b0, 8);
      run_frame(4, 4, 4, 0, 1'b0, -1);

      // 3x3 frame, pixels 0..8
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            img[r][c] = 3 * r + c;
      run_frame(3, 3, 3, 0, 1'b0, -1);

      // 8x8 random pixels with random stalls
      lin_img = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
               img[r][c] = int'($urandom_range(0, 15));
         run_frame(8, 8, 8, 2, 1'b0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
